xosera_spi_host: RTL

- SPI controller (initiator) that drives the Xosera SPI target interface: SCK, COPI, CS, and samples CIPO.
- Used by the host-side FPGA and bench harness to issue byte streams to xosera_main.
- Byte-wide valid/ready command input, full-duplex received-byte output, SPI mode 0.
- CS stays asserted across multi-byte transactions until a byte tagged "last" completes.

---
 rtl/xosera_spi_host.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/xosera_spi_host.sv
// SPI mode-0 initiator driving the Xosera SPI target; byte-wide valid/ready in, full-duplex byte out.
// Optional build macro XOSERA_SPI_HOST_LSB_FIRST_EN selects LSB-first bit order in both directions.
module xosera_spi_host #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_copi_o,
  input  logic       spi_cipo_i,
  output logic       spi_cs_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

  function automatic logic [7:0] bit_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef XOSERA_SPI_HOST_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  state_t     state_q;
  logic [7:0] cnt_q, ph_q, rx_byte_q;
  logic [6:0] tx_sh_q, rx_sh_q;
  logic [2:0] bit_q;
  logic       last_q, ready_q, busy_q, sck_q, copi_q, cs_q, rx_valid_q;
  logic       accept;
  logic [7:0] tx_ord, rx_next;

  // Handshake: a byte transfers on a rising clk where tx_valid_i && tx_ready_o;
  // tx_ready_o is registered and never depends on tx_valid_i.
  assign accept  = tx_valid_i && ready_q;
  assign tx_ord  = bit_order(tx_byte_i);
  assign rx_next = {rx_sh_q, spi_cipo_i};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      ph_q       <= 8'd0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 7'd0;
      rx_sh_q    <= 7'd0;
      rx_byte_q  <= 8'd0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      sck_q      <= 1'b0;
      copi_q     <= 1'b0;
      cs_q       <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tx_sh_q <= tx_ord[6:0];
            copi_q  <= tx_ord[7];
            last_q  <= tx_last_i;
            ph_q    <= 8'd0;
            bit_q   <= 3'd0;
            cnt_q   <= SETUP_LD;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_q == 8'd0) state_q <= S_SHIFT;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        S_SHIFT: begin
          if (ph_q == PH_LAST) begin
            ph_q <= 8'd0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // End of the high phase: sample CIPO, drop SCK, present the next bit.
              sck_q   <= 1'b0;
              rx_sh_q <= rx_next[6:0];
              tx_sh_q <= {tx_sh_q[5:0], 1'b0};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                rx_byte_q  <= bit_order(rx_next);
                rx_valid_q <= 1'b1;
                if (last_q) begin
                  cnt_q   <= HOLD_LD;
                  state_q <= S_HOLD;
                end else begin
                  ready_q <= 1'b1;
                  state_q <= S_WAIT;
                end
              end else begin
                copi_q <= tx_sh_q[6];
              end
            end
          end else begin
            ph_q <= ph_q + 8'd1;
          end
        end
        S_WAIT: begin
          if (accept) begin
            tx_sh_q <= tx_ord[6:0];
            copi_q  <= tx_ord[7];
            last_q  <= tx_last_i;
            ph_q    <= 8'd0;
            bit_q   <= 3'd0;
            ready_q <= 1'b0;
            state_q <= S_SHIFT;
          end
        end
        S_HOLD: begin
          // The rx_valid_o cycle counts toward the hold, hence CS_HOLD+1 cycles here.
          if (cnt_q == 8'd0) begin
            cs_q    <= 1'b1;
            cnt_q   <= GAP_LD;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == 8'd0) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready_o  = ready_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = busy_q;
  assign spi_sck_o   = sck_q;
  assign spi_copi_o  = copi_q;
  assign spi_cs_o    = cs_q;
  assign dbg_state_o = state_q;

endmodule
